// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive frame sequencer; oversamples the line and strobes sampler/checkers mid-bit.
// Define UART_RX_FRAME_ERR_EN to add the o_frame_err output (rejected-frame / start-glitch pulse).
module uart_rx_ctrl #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx_in,
    input  logic                          i_par_en,
    input  logic                          i_strt_glitch,
    input  logic                          i_par_err,
    input  logic                          i_stop_err,
    output logic                          o_samp_en,
    output logic                          o_strt_chk_en,
    output logic                          o_par_chk_en,
    output logic                          o_stop_chk_en,
    output logic                          o_deser_en,
    output logic [$clog2(DATA_WIDTH)-1:0] o_bit_idx,
    output logic [$clog2(PRESCALE)-1:0]   o_edge_cnt,
    output logic                          o_data_valid,
`ifdef UART_RX_FRAME_ERR_EN
    output logic                          o_frame_err,
`endif
    output logic                          o_busy
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam int EW = $clog2(PRESCALE);

    localparam logic [EW-1:0] WIN_LO    = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] WIN_HI    = EW'(PRESCALE / 2 + 1);
    localparam logic [EW-1:0] CHK_EDGE  = EW'(PRESCALE / 2 + 2);
    localparam logic [EW-1:0] LAST_EDGE = EW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [EW-1:0]   r_edge_cnt;
    logic [IW-1:0]   r_bit_idx;
    logic            r_err_flag;
    logic            r_par_en_q;
    logic            w_bit_end;
    logic            w_at_chk;
    logic            w_in_win;
    logic            w_new_frame;

    assign w_bit_end   = (r_edge_cnt == LAST_EDGE);
    assign w_at_chk    = (r_edge_cnt == CHK_EDGE);
    assign w_in_win    = (r_edge_cnt >= WIN_LO) && (r_edge_cnt <= WIN_HI);
    assign w_new_frame = (w_next_state == S_START) &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));

    // The detect cycle counts as oversample 0 of the start bit, so a new frame resumes at 1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_idx  <= '0;
            r_err_flag <= 1'b0;
            r_par_en_q <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if (w_new_frame)
                r_edge_cnt <= EW'(1);
            else if ((w_next_state == S_IDLE) || (w_next_state == S_DONE) || w_bit_end)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + 1'b1;

            if (w_next_state != S_DATA)
                r_bit_idx <= '0;
            else if ((r_state == S_DATA) && w_bit_end)
                r_bit_idx <= r_bit_idx + 1'b1;

            if ((r_state == S_IDLE) && w_new_frame)
                r_par_en_q <= i_par_en;

            if (r_state == S_DONE)
                r_err_flag <= 1'b0;
            else if ((r_state == S_PARITY) && w_at_chk)
                r_err_flag <= r_err_flag | i_par_err;
            else if ((r_state == S_STOP) && w_at_chk)
                r_err_flag <= r_err_flag | i_stop_err;
        end
    end

    // A start glitch is only looked at on the check point, which always precedes the bit end.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!i_rx_in) w_next_state = S_START;
            S_START: begin
                if (w_at_chk && i_strt_glitch) w_next_state = S_IDLE;
                else if (w_bit_end)            w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == LAST_BIT))
                    w_next_state = r_par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
            S_STOP:   if (w_bit_end) w_next_state = S_DONE;
            S_DONE:   w_next_state = i_rx_in ? S_IDLE : S_START;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_samp_en     = 1'b0;
        o_strt_chk_en = 1'b0;
        o_par_chk_en  = 1'b0;
        o_stop_chk_en = 1'b0;
        o_deser_en    = 1'b0;
        o_data_valid  = (r_state == S_DONE) && !r_err_flag;
        o_busy        = (r_state != S_IDLE);
        case (r_state)
            S_START: begin
                o_samp_en     = w_in_win;
                o_strt_chk_en = w_at_chk;
            end
            S_DATA: begin
                o_samp_en  = w_in_win;
                o_deser_en = w_at_chk;
            end
            S_PARITY: begin
                o_samp_en    = w_in_win;
                o_par_chk_en = w_at_chk;
            end
            S_STOP: begin
                o_samp_en     = w_in_win;
                o_stop_chk_en = w_at_chk;
            end
            default: ;
        endcase
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_idx  = r_bit_idx;

`ifdef UART_RX_FRAME_ERR_EN
    logic r_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_abort <= 1'b0;
        else
            r_abort <= (r_state == S_START) && (w_next_state == S_IDLE);
    end

    assign o_frame_err = ((r_state == S_DONE) && r_err_flag) || r_abort;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl at PRESCALE=8, DATA_WIDTH=8.
// Strobe/valid events are queued when a frame is driven and matched as the DUT emits them.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int P  = 8;
    localparam int DW = 8;
    localparam int C  = P / 2 + 2;
    localparam int IW = $clog2(DW);
    localparam int EW = $clog2(P);
    localparam int SW = 2 + EW + IW;

    localparam logic [5:0] EV_STRT  = 6'b000001;
    localparam logic [5:0] EV_DESER = 6'b000010;
    localparam logic [5:0] EV_PAR   = 6'b000100;
    localparam logic [5:0] EV_STOP  = 6'b001000;
    localparam logic [5:0] EV_DV    = 6'b010000;
    localparam logic [5:0] EV_FE    = 6'b100000;
`ifdef UART_RX_FRAME_ERR_EN
    localparam logic [5:0] EV_MASK  = 6'b111111;
`else
    localparam logic [5:0] EV_MASK  = 6'b011111;
`endif

    typedef struct {
        int         cyc;
        logic [5:0] ev;
    } scoreEvent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rxIn;
    logic          parEn;
    logic          strtGlitch;
    logic          parErr;
    logic          stopErr;
    logic          sampEn;
    logic          strtChkEn;
    logic          parChkEn;
    logic          stopChkEn;
    logic          deserEn;
    logic [IW-1:0] bitIdx;
    logic [EW-1:0] edgeCnt;
    logic          dataValid;
    logic          busy;
`ifdef UART_RX_FRAME_ERR_EN
    logic          frameErr;
`endif

    scoreEvent_t   scoreQ[$];
    int            vecCount  = 0;
    int            missCount = 0;
    int            frameLen;
    int            busyEnd;
    int            lineEnd;
    logic [DW-1:0] frameData;
    bit            frameParity;

    uart_rx_ctrl #(
        .PRESCALE   (P),
        .DATA_WIDTH (DW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_in       (rxIn),
        .i_par_en      (parEn),
        .i_strt_glitch (strtGlitch),
        .i_par_err     (parErr),
        .i_stop_err    (stopErr),
        .o_samp_en     (sampEn),
        .o_strt_chk_en (strtChkEn),
        .o_par_chk_en  (parChkEn),
        .o_stop_chk_en (stopChkEn),
        .o_deser_en    (deserEn),
        .o_bit_idx     (bitIdx),
        .o_edge_cnt    (edgeCnt),
        .o_data_valid  (dataValid),
`ifdef UART_RX_FRAME_ERR_EN
        .o_frame_err   (frameErr),
`endif
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Serial line for frame-relative cycle k; frames repeat every frameLen cycles until lineEnd.
    function automatic logic line_bit(int k);
        int b;
        if (k >= lineEnd) return 1'b1;
        b = (k % frameLen) / P;
        if (b == 0) return 1'b0;
        if (b <= DW) return frameData[b-1];
        if (frameParity && (b == DW + 1)) return ^frameData;
        return 1'b1;
    endfunction

    // Time-based reference: busy/samp_en/edge_cnt/bit_idx follow directly from the cycle offset.
    function automatic logic [SW-1:0] model_state(int k);
        logic          bz;
        logic          s;
        logic [EW-1:0] e;
        logic [IW-1:0] ix;
        int            b;
        bz = (k >= 1) && (k <= busyEnd);
        e  = bz ? EW'(k % P) : '0;
        s  = bz && ((k % P) >= P / 2 - 1) && ((k % P) <= P / 2 + 1);
        b  = (k % frameLen) / P;
        ix = (bz && (b >= 1) && (b <= DW)) ? IW'(b - 1) : '0;
        return {bz, s, e, ix};
    endfunction

    function automatic logic [5:0] obs_events();
        logic fe;
`ifdef UART_RX_FRAME_ERR_EN
        fe = frameErr;
`else
        fe = 1'b0;
`endif
        return {fe, dataValid, stopChkEn, parChkEn, deserEn, strtChkEn};
    endfunction

    function automatic logic [15:0] all_outputs();
        logic [15:0] v;
        v        = '0;
        v[6:0]   = {sampEn, strtChkEn, parChkEn, stopChkEn, deserEn, dataValid, busy};
        v[7+:IW] = bitIdx;
        v[10+:EW] = edgeCnt;
`ifdef UART_RX_FRAME_ERR_EN
        v[15]    = frameErr;
`endif
        return v;
    endfunction

    function automatic void push_ev(int cyc, logic [5:0] ev);
        scoreEvent_t e;
        e.cyc = cyc;
        e.ev  = ev & EV_MASK;
        scoreQ.push_back(e);
    endfunction

    // Every strobe and the DONE-cycle verdict of one frame whose detect cycle is 'base'.
    function automatic void push_frame(int base, bit parity, logic dv, logic fe);
        int pb;
        pb = parity ? 1 : 0;
        push_ev(base + C, EV_STRT);
        for (int i = 0; i < DW; i++) push_ev(base + P * (i + 1) + C, EV_DESER);
        if (parity) push_ev(base + P * (DW + 1) + C, EV_PAR);
        push_ev(base + P * (DW + 1 + pb) + C, EV_STOP);
        push_ev(base + P * (DW + 2 + pb), (dv ? EV_DV : 6'b0) | (fe ? EV_FE : 6'b0));
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        rxIn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            vecCount++;
            if (all_outputs() !== 16'h0) begin
                missCount++;
                $display("[TB] FAIL reset_hold: outputs %h, want 0000", all_outputs());
            end
        end
        rst = 1'b0;
        rxIn = 1'b1;
        @(negedge clk);
        vecCount++;
        if (all_outputs() !== 16'h0) begin
            missCount++;
            $display("[TB] FAIL reset_release: outputs %h, want 0000", all_outputs());
        end
    endtask

    task automatic test_clean_frame();
        logic [SW-1:0] expState;
        logic [5:0]    obs;
        logic [5:0]    expEv;
        scoreEvent_t   e;
        frameData = 8'hA5; frameParity = 0; frameLen = 80; busyEnd = 80; lineEnd = 80;
        push_frame(0, 0, 1'b1, 1'b0);
        for (int k = 0; k <= busyEnd + 3; k++) begin
            expState = model_state(k);
            vecCount++;
            if ({busy, sampEn, edgeCnt, bitIdx} !== expState) begin
                missCount++;
                $display("[TB] FAIL clean_state cycle %0d: got %b, want %b", k, {busy, sampEn, edgeCnt, bitIdx}, expState);
            end
            obs = obs_events();
            if ((obs != 6'b0) || ((scoreQ.size() != 0) && (scoreQ[0].cyc == k))) begin
                expEv = 6'b0;
                if ((scoreQ.size() != 0) && (scoreQ[0].cyc == k)) begin
                    e = scoreQ.pop_front();
                    expEv = e.ev;
                end
                vecCount++;
                if (obs !== expEv) begin
                    missCount++;
                    $display("[TB] FAIL clean_events cycle %0d: got %b, want %b", k, obs, expEv);
                end
            end
            rxIn       = line_bit(k);
            parEn      = (k >= 30) && (k < 60);
            strtGlitch = (k == C - 1) || (k == C + 1);
            stopErr    = (k == 77) || (k == 79);
            @(negedge clk);
        end
        parEn = 1'b0; strtGlitch = 1'b0; stopErr = 1'b0;
        vecCount++;
        if (scoreQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL clean_missing: %0d events never seen, want 0", scoreQ.size());
        end
        scoreQ.delete();
    endtask

    task automatic test_parity_err();
        logic [SW-1:0] expState;
        logic [5:0]    obs;
        logic [5:0]    expEv;
        scoreEvent_t   e;
        frameData = 8'h3C; frameParity = 1; frameLen = 88; busyEnd = 88; lineEnd = 88;
        push_frame(0, 1, 1'b0, 1'b1);
        for (int k = 0; k <= busyEnd + 3; k++) begin
            expState = model_state(k);
            vecCount++;
            if ({busy, sampEn, edgeCnt, bitIdx} !== expState) begin
                missCount++;
                $display("[TB] FAIL parity_state cycle %0d: got %b, want %b", k, {busy, sampEn, edgeCnt, bitIdx}, expState);
            end
            obs = obs_events();
            if ((obs != 6'b0) || ((scoreQ.size() != 0) && (scoreQ[0].cyc == k))) begin
                expEv = 6'b0;
                if ((scoreQ.size() != 0) && (scoreQ[0].cyc == k)) begin
                    e = scoreQ.pop_front();
                    expEv = e.ev;
                end
                vecCount++;
                if (obs !== expEv) begin
                    missCount++;
                    $display("[TB] FAIL parity_events cycle %0d: got %b, want %b", k, obs, expEv);
                end
            end
            rxIn   = line_bit(k);
            parEn  = (k < 20);
            parErr = (k == 78);
            @(negedge clk);
        end
        parEn = 1'b0; parErr = 1'b0;
        vecCount++;
        if (scoreQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL parity_missing: %0d events never seen, want 0", scoreQ.size());
        end
        scoreQ.delete();
    endtask

    task automatic test_start_glitch();
        logic [SW-1:0] expState;
        logic [5:0]    obs;
        logic [5:0]    expEv;
        scoreEvent_t   e;
        frameData = 8'hFF; frameParity = 0; frameLen = 80; busyEnd = C; lineEnd = 2;
        push_ev(C, EV_STRT);
        push_ev(C + 1, EV_FE);
        for (int k = 0; k <= busyEnd + 4; k++) begin
            expState = model_state(k);
            vecCount++;
            if ({busy, sampEn, edgeCnt, bitIdx} !== expState) begin
                missCount++;
                $display("[TB] FAIL glitch_state cycle %0d: got %b, want %b", k, {busy, sampEn, edgeCnt, bitIdx}, expState);
            end
            obs = obs_events();
            if ((obs != 6'b0) || ((scoreQ.size() != 0) && (scoreQ[0].cyc == k))) begin
                expEv = 6'b0;
                if ((scoreQ.size() != 0) && (scoreQ[0].cyc == k)) begin
                    e = scoreQ.pop_front();
                    expEv = e.ev;
                end
                vecCount++;
                if (obs !== expEv) begin
                    missCount++;
                    $display("[TB] FAIL glitch_events cycle %0d: got %b, want %b", k, obs, expEv);
                end
            end
            rxIn       = line_bit(k);
            strtGlitch = (k == C);
            @(negedge clk);
        end
        strtGlitch = 1'b0;
        vecCount++;
        if (scoreQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL glitch_missing: %0d events never seen, want 0", scoreQ.size());
        end
        scoreQ.delete();
    endtask

    task automatic test_stop_err();
        logic [SW-1:0] expState;
        logic [5:0]    obs;
        logic [5:0]    expEv;
        scoreEvent_t   e;
        frameData = 8'h5A; frameParity = 0; frameLen = 80; busyEnd = 80; lineEnd = 80;
        push_frame(0, 0, 1'b0, 1'b1);
        for (int k = 0; k <= busyEnd + 3; k++) begin
            expState = model_state(k);
            vecCount++;
            if ({busy, sampEn, edgeCnt, bitIdx} !== expState) begin
                missCount++;
                $display("[TB] FAIL stop_state cycle %0d: got %b, want %b", k, {busy, sampEn, edgeCnt, bitIdx}, expState);
            end
            obs = obs_events();
            if ((obs != 6'b0) || ((scoreQ.size() != 0) && (scoreQ[0].cyc == k))) begin
                expEv = 6'b0;
                if ((scoreQ.size() != 0) && (scoreQ[0].cyc == k)) begin
                    e = scoreQ.pop_front();
                    expEv = e.ev;
                end
                vecCount++;
                if (obs !== expEv) begin
                    missCount++;
                    $display("[TB] FAIL stop_events cycle %0d: got %b, want %b", k, obs, expEv);
                end
            end
            rxIn    = line_bit(k);
            stopErr = (k == 78);
            @(negedge clk);
        end
        stopErr = 1'b0;
        vecCount++;
        if (scoreQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL stop_missing: %0d events never seen, want 0", scoreQ.size());
        end
        scoreQ.delete();
    endtask

    // Second start bit begins in the first frame's DONE cycle; a stale error flag would reject frame two.
    task automatic test_back_to_back();
        logic [SW-1:0] expState;
        logic [5:0]    obs;
        logic [5:0]    expEv;
        scoreEvent_t   e;
        frameData = 8'hA5; frameParity = 0; frameLen = 80; busyEnd = 160; lineEnd = 160;
        push_frame(0, 0, 1'b1, 1'b0);
        push_frame(80, 0, 1'b1, 1'b0);
        for (int k = 0; k <= busyEnd + 3; k++) begin
            expState = model_state(k);
            vecCount++;
            if ({busy, sampEn, edgeCnt, bitIdx} !== expState) begin
                missCount++;
                $display("[TB] FAIL b2b_state cycle %0d: got %b, want %b", k, {busy, sampEn, edgeCnt, bitIdx}, expState);
            end
            obs = obs_events();
            if ((obs != 6'b0) || ((scoreQ.size() != 0) && (scoreQ[0].cyc == k))) begin
                expEv = 6'b0;
                if ((scoreQ.size() != 0) && (scoreQ[0].cyc == k)) begin
                    e = scoreQ.pop_front();
                    expEv = e.ev;
                end
                vecCount++;
                if (obs !== expEv) begin
                    missCount++;
                    $display("[TB] FAIL b2b_events cycle %0d: got %b, want %b", k, obs, expEv);
                end
            end
            rxIn = line_bit(k);
            @(negedge clk);
        end
        vecCount++;
        if (scoreQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL b2b_missing: %0d events never seen, want 0", scoreQ.size());
        end
        scoreQ.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [SW-1:0] expState;
        logic [5:0]    obs;
        logic [5:0]    expEv;
        scoreEvent_t   e;
        frameData = 8'hA5; frameParity = 0; frameLen = 80; busyEnd = 40; lineEnd = 41;
        push_ev(C, EV_STRT);
        for (int i = 0; i < 4; i++) push_ev(P * (i + 1) + C, EV_DESER);
        for (int k = 0; k <= busyEnd + 6; k++) begin
            expState = model_state(k);
            vecCount++;
            if ({busy, sampEn, edgeCnt, bitIdx} !== expState) begin
                missCount++;
                $display("[TB] FAIL rstmid_state cycle %0d: got %b, want %b", k, {busy, sampEn, edgeCnt, bitIdx}, expState);
            end
            if (k == busyEnd + 1) begin
                vecCount++;
                if (all_outputs() !== 16'h0) begin
                    missCount++;
                    $display("[TB] FAIL rstmid_outputs: outputs %h, want 0000", all_outputs());
                end
            end
            obs = obs_events();
            if ((obs != 6'b0) || ((scoreQ.size() != 0) && (scoreQ[0].cyc == k))) begin
                expEv = 6'b0;
                if ((scoreQ.size() != 0) && (scoreQ[0].cyc == k)) begin
                    e = scoreQ.pop_front();
                    expEv = e.ev;
                end
                vecCount++;
                if (obs !== expEv) begin
                    missCount++;
                    $display("[TB] FAIL rstmid_events cycle %0d: got %b, want %b", k, obs, expEv);
                end
            end
            rxIn = line_bit(k);
            rst  = (k == 40);
            @(negedge clk);
        end
        rst = 1'b0;
        vecCount++;
        if (scoreQ.size() != 0) begin
            missCount++;
            $display("[TB] FAIL rstmid_missing: %0d events never seen, want 0", scoreQ.size());
        end
        scoreQ.delete();
    endtask

    initial begin
        rst        = 1'b1;
        rxIn       = 1'b1;
        parEn      = 1'b0;
        strtGlitch = 1'b0;
        parErr     = 1'b0;
        stopErr    = 1'b0;
        frameLen   = 80;
        busyEnd    = 0;
        lineEnd    = 0;
        frameData  = '0;
        frameParity = 0;
        $display("[TB] starting uart_rx_ctrl bench");
        test_reset();
        test_clean_frame();
        test_parity_err();
        test_start_glitch();
        test_stop_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
